// File: rtl/msg_block_ctrl.sv
// rtl/msg_block_ctrl.sv - SHA-256 message fetch, big-endian packing and FIPS 180-4 padding into 512-bit blocks
// Optional feature macro: CTRL_LEN_CHECK_EN (reject oversize lengths with a len_err pulse instead of saturating)
module msg_block_ctrl #(
    parameter int MAX_MSG_BYTES = 119,
    parameter int ADDR_W        = $clog2(MAX_MSG_BYTES),
    parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_length,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              block_valid,
    input  logic              block_ready,
    output logic [511:0]      block_data,
    output logic              block_last,
    output logic              busy,
    output logic              done
`ifdef CTRL_LEN_CHECK_EN
    ,
    output logic              len_err
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] FILL  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_MSG_BYTES);

    logic [2:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] addr;
    logic [LEN_W-1:0] addr_nxt;
    logic [6:0]       rd_cnt;
    logic [6:0]       p;
    logic             rd_pend;
    logic             pad_done;
    logic             last_q;
    logic [511:0]     blk;
    logic [LEN_W-1:0] len_in;
    logic             len_bad;
    logic             msg_end;
    logic [63:0]      len_field;

`ifdef CTRL_LEN_CHECK_EN
    assign len_in  = msg_length;
    assign len_bad = (msg_length > MAX_LEN);
`else
    assign len_in  = (msg_length > MAX_LEN) ? MAX_LEN : msg_length;
    assign len_bad = 1'b0;
`endif

    assign addr_nxt  = addr + LEN_W'(1);
    assign msg_end   = (addr == len_q);
    assign len_field = {{(61 - LEN_W){1'b0}}, len_q, 3'b000};

    assign mem_rd      = (state == READ);
    assign mem_addr    = mem_rd ? addr[ADDR_W-1:0] : '0;
    assign block_valid = (state == HOLD);
    assign block_data  = blk;
    assign block_last  = last_q;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            addr     <= '0;
            rd_cnt   <= '0;
            p        <= '0;
            rd_pend  <= 1'b0;
            pad_done <= 1'b0;
            last_q   <= 1'b0;
            blk      <= '0;
`ifdef CTRL_LEN_CHECK_EN
            len_err  <= 1'b0;
`endif
        end else begin
            rd_pend <= (state == READ);
`ifdef CTRL_LEN_CHECK_EN
            len_err <= 1'b0;
`endif
            // RAM data returns one cycle after the strobe; slot k lives at bits [511-8k -: 8]
            if (rd_pend) begin
                blk[{~p[5:0], 3'b000} +: 8] <= mem_data;
                p                           <= p + 7'd1;
            end

            case (state)
                IDLE: begin
                    if (start && len_bad) begin
`ifdef CTRL_LEN_CHECK_EN
                        len_err <= 1'b1;
`endif
                    end else if (start) begin
                        len_q    <= len_in;
                        addr     <= '0;
                        rd_cnt   <= '0;
                        p        <= '0;
                        blk      <= '0;
                        pad_done <= 1'b0;
                        last_q   <= 1'b0;
                        state    <= (len_in == '0) ? FILL : READ;
                    end
                end
                READ: begin
                    addr   <= addr_nxt;
                    rd_cnt <= rd_cnt + 7'd1;
                    if (addr_nxt == len_q || rd_cnt == 7'd63)
                        state <= DRAIN;
                end
                DRAIN: state <= FILL;
                FILL: begin
                    if (msg_end && !pad_done && p < 7'd64) begin
                        blk[{~p[5:0], 3'b000} +: 8] <= 8'h80;
                        pad_done                    <= 1'b1;
                    end
                    // Length goes in only if the 0x80 marker (new or earlier) leaves bytes 56..63 free
                    if (msg_end && (pad_done || p <= 7'd55)) begin
                        blk[63:0] <= len_field;
                        last_q    <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (block_ready) begin
                        blk    <= '0;
                        p      <= '0;
                        rd_cnt <= '0;
                        last_q <= 1'b0;
                        if (last_q)
                            state <= DONE;
                        else if (addr < len_q)
                            state <= READ;
                        else
                            state <= FILL;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_block_ctrl.sv
// tb/tb_msg_block_ctrl.sv - directed self-checking bench for msg_block_ctrl
module tb_msg_block_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [6:0]   msg_length;
    logic         mem_rd;
    logic [6:0]   mem_addr;
    logic [7:0]   mem_data;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         block_last;
    logic         busy;
    logic         done;
`ifdef CTRL_LEN_CHECK_EN
    logic         len_err;
`endif

    logic [7:0]   mem [0:127];
    int           n_checks = 0;
    int           n_fail   = 0;

    msg_block_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .msg_length  (msg_length),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .block_last  (block_last),
        .busy        (busy),
`ifdef CTRL_LEN_CHECK_EN
        .len_err     (len_err),
`endif
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_data <= mem_rd ? mem[mem_addr] : 8'h00;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic start_msg(input logic [6:0] len);
        start      = 1'b1;
        msg_length = len;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int reads);
        int i;
        reads = 0;
        i     = 0;
        do begin
            @(negedge clock);
            if (mem_rd) reads++;
            i++;
        end while (!block_valid && i < budget);
        if (!block_valid) check("wait_valid_timeout", block_valid, 1'b1);
    endtask

    function automatic logic [511:0] mk(input int nbytes, input int base, input int pad,
                                        input bit has_len, input logic [63:0] len);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < nbytes; k++) b[511-8*k -: 8] = 8'(base + k);
        if (pad >= 0) b[511-8*pad -: 8] = 8'h80;
        if (has_len) b[63:0] = len;
        return b;
    endfunction

    initial begin
        logic [511:0] abc_blk;
        logic [511:0] held;
        logic         stable;
        int           reads;

        abc_blk     = {24'h616263, 8'h80, 416'h0, 64'h18};
        reset       = 1'b1;
        start       = 1'b0;
        msg_length  = '0;
        block_ready = 1'b0;
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
        for (int i = 3; i < 128; i++) mem[i] = 8'hEE;
        repeat (3) cyc();
        check("rst_valid", block_valid, 1'b0);
        check("rst_data", block_data, '0);
        check("rst_busy_done_rd_last", {busy, done, mem_rd, block_last}, 4'b0000);
        reset = 1'b0;
        cyc();

        // "abc" with ready held high, cycle-exact
        block_ready = 1'b1;
        start_msg(7'd3);
        cyc();
        check("abc_c1", {mem_rd, busy, mem_addr}, {2'b11, 7'd0});
        cyc();
        check("abc_c2", {mem_rd, mem_addr}, {1'b1, 7'd1});
        cyc();
        check("abc_c3", {mem_rd, mem_addr}, {1'b1, 7'd2});
        cyc();
        check("abc_c4_drain", {mem_rd, block_valid}, 2'b00);
        cyc();
        check("abc_c5_fill", block_valid, 1'b0);
        cyc();
        check("abc_c6_valid_last", {block_valid, block_last}, 2'b11);
        check("abc_c6_data", block_data, abc_blk);
        cyc();
        check("abc_c7_done", {done, block_valid}, 2'b10);
        cyc();
        check("abc_c8_idle", {done, busy}, 2'b00);

        // zero-length message
        start_msg(7'd0);
        cyc();
        check("l0_c1", {mem_rd, busy, block_valid}, 3'b010);
        cyc();
        check("l0_c2_valid_last", {block_valid, block_last}, 2'b11);
        check("l0_c2_data", block_data, {8'h80, 504'h0});
        cyc();
        check("l0_done", done, 1'b1);
        cyc();

        // backpressure: block must hold for 10 cycles with no reads
        block_ready = 1'b0;
        start_msg(7'd3);
        wait_valid(20, reads);
        check("bp_reads", reads, 3);
        check("bp_data", block_data, abc_blk);
        held   = block_data;
        stable = 1'b1;
        repeat (10) begin
            cyc();
            if (!block_valid || block_data !== held || mem_rd) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        block_ready = 1'b1;
        cyc();
        check("bp_done", {done, block_valid}, 2'b10);
        cyc();

        // start pulsed during HOLD is ignored
        block_ready = 1'b0;
        start_msg(7'd3);
        wait_valid(20, reads);
        start      = 1'b1;
        msg_length = 7'd0;
        cyc();
        start = 1'b0;
        check("hold_start_ign", {block_valid, busy, block_last}, 3'b111);
        check("hold_start_data", block_data, abc_blk);
        block_ready = 1'b1;
        cyc();
        check("hold_start_done", done, 1'b1);
        cyc();
        check("hold_start_idle", busy, 1'b0);

        // reset mid-READ, then a clean "abc" with different RAM contents
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
        start_msg(7'd3);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("mid_rst", {mem_rd, busy, block_valid}, 3'b000);
        reset = 1'b0;
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
        cyc();
        start_msg(7'd3);
        wait_valid(20, reads);
        check("post_rst_data", block_data, abc_blk);
        check("post_rst_last", block_last, 1'b1);
        cyc();
        cyc();

        for (int i = 0; i < 128; i++) mem[i] = 8'(i);

        // L=56: marker at slot 56 of block 0, length-only block 1
        start_msg(7'd56);
        wait_valid(200, reads);
        check("l56_reads", reads, 56);
        check("l56_b0", block_data, mk(56, 0, 56, 1'b0, 64'h0));
        check("l56_b0_last", block_last, 1'b0);
        wait_valid(10, reads);
        check("l56_b1", block_data, mk(0, 0, -1, 1'b1, 64'h1C0));
        check("l56_b1_last_reads", {block_last, 7'(reads)}, {1'b1, 7'd0});
        cyc();
        check("l56_done", done, 1'b1);
        cyc();

        // L=64: full data block, marker at slot 0 of block 1
        start_msg(7'd64);
        wait_valid(200, reads);
        check("l64_reads", reads, 64);
        check("l64_b0", block_data, mk(64, 0, -1, 1'b0, 64'h0));
        check("l64_b0_last", block_last, 1'b0);
        wait_valid(10, reads);
        check("l64_b1", block_data, mk(0, 0, 0, 1'b1, 64'h200));
        check("l64_b1_last", block_last, 1'b1);
        cyc();
        check("l64_done", done, 1'b1);
        cyc();

`ifdef CTRL_LEN_CHECK_EN
        start_msg(7'd120);
        cyc();
        check("l120_len_err", {len_err, busy}, 2'b10);
        cyc();
        check("l120_len_err_pulse", {len_err, busy}, 2'b00);
`else
        // oversize length saturates to 119 bytes
        start_msg(7'd120);
        wait_valid(200, reads);
        check("sat_b0_reads", reads, 64);
        check("sat_b0", block_data, mk(64, 0, -1, 1'b0, 64'h0));
        wait_valid(200, reads);
        check("sat_b1_reads", reads, 55);
        check("sat_b1", block_data, mk(55, 64, 55, 1'b1, 64'h3B8));
        check("sat_b1_last", block_last, 1'b1);
        cyc();
        check("sat_done", done, 1'b1);
`endif
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
